fib_job_scheduler: RTL and testbench
====================================

// Module: fib_job_scheduler
//
// PURPOSE
//   Shares one iterative Fibonacci engine among NREQ requesters.
//   Each requester asks for term F(n) over a valid/ready handshake.
//   A round-robin arbiter grants one job at a time. The engine steps the
//   a/b recurrence once per clock. The result, requester id and an
//   overflow flag are returned on a single response channel.
//   Sits between client blocks and the Fibonacci datapath; it is the
//   only block allowed to sequence that datapath.
//
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   WIDTH  14  result width; f values wrap modulo 2**WIDTH
//   IDXW   5   width of term index n (n = 0 .. 2**IDXW-1)
//
// PORTS
//   clk        in   1               clock, rising edge
//   clr        in   1               synchronous, active-low reset
//   req_valid  in   NREQ            per-requester job request
//   req_index  in   NREQ*IDXW       requester i's n at [i*IDXW +: IDXW]
//   req_ready  out  NREQ            one-hot grant; accept = valid & ready
//   rsp_valid  out  1               result available
//   rsp_ready  in   1               consumer takes result
//   rsp_id     out  $clog2(NREQ)    requester that owns the result
//   rsp_f      out  WIDTH           F(n) mod 2**WIDTH
//   rsp_ovf    out  1               true F(n) > 2**WIDTH-1
//   busy       out  1               state != IDLE
//
// BEHAVIOUR
//   Reset (clr==0 at a clk edge):
//   - state=IDLE, ptr=NREQ-1, all registers cleared.
//   - rsp_valid/rsp_id/rsp_f/rsp_ovf/busy = 0.
//   - req_ready forced 0 while clr==0.
//   - Reset mid-job discards the job silently; no response is produced.
//   FSM: IDLE -> CALC -> RESP -> IDLE.
//   IDLE:
//   - Round-robin search starts at ptr+1 (wraps at NREQ); the first
//     asserted req_valid wins.
//   - req_ready is combinational and asserted only for the winner.
//     All req_ready are 0 in CALC and RESP.
//   - On accept: latch id and n; a=0, b=1, cnt=0, a_ovf=0, b_ovf=0;
//     go to CALC.
//   - req_index is sampled only on the accept edge; later changes have
//     no effect.
//   CALC, once per clock:
//   - If cnt==n: load rsp_f=a, rsp_ovf=a_ovf; go to RESP.
//   - Else: a<=b, a_ovf<=b_ovf; b<=(a+b) mod 2**WIDTH;
//     b_ovf<=b_ovf | a_ovf | carry(a+b); cnt<=cnt+1.
//   - Sum is computed WIDTH+1 bits wide. Wrapped values keep iterating;
//     the ovf flags are sticky, so rsp_ovf is exact for the returned term.
//   - With F(0)=0 and F(1)=1, rsp_valid rises n+1 clocks after the
//     accept edge.
//   RESP:
//   - rsp_valid=1; rsp_id/rsp_f/rsp_ovf held stable until rsp_ready==1.
//   - On that edge: rsp_valid<=0, ptr<=rsp_id, go to IDLE.
//   - rsp_valid never drops without a handshake, except on reset.
//   Throughput:
//   - At least one IDLE cycle between jobs, so one job per n+3 clocks
//     with rsp_ready held high.
//   - No job queueing; losers keep req_valid high and wait.
//   Fairness: the requester just served has lowest priority next round,
//   so no starvation.
//
// TESTING
//   1. req0 with n=0,1,2,10 in turn, rsp_ready=1 -> rsp_f=0,1,1,55,
//      rsp_ovf=0, rsp_id=0; rsp_valid exactly n+1 clocks after accept.
//   2. n=20 -> 6765, ovf=0; n=21 -> 10946, ovf=0;
//      n=22 -> 1327, ovf=1; n=31 -> ovf=1.
//   3. All four req_valid held high, each n=3 -> accept order 0,1,2,3,0;
//      rsp_id follows the same order and every rsp_f=2.
//   4. rsp_ready held low 5 clocks in RESP -> rsp_* stable, req_ready=0,
//      busy=1; accept only after the rsp_ready handshake.
//   5. clr low for one clock mid-CALC (n=15) -> no response, busy=0;
//      with req3 and req0 both valid, req0 is granted first (ptr reset).
//   6. req3 served, then only req2 valid -> req2 granted (wrap);
//      req_index changed after accept -> result uses the latched n.

Source files
------------

// File: rtl/fib_job_scheduler.sv
// Shares one iterative Fibonacci engine among NREQ requesters. A round-robin arbiter grants
// one job at a time, and results return on a single valid/ready response channel.
module fib_job_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 14,
    parameter int unsigned IDXW  = 5,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IDXW-1:0] req_index,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [WIDTH-1:0]     rsp_f,
    output logic                 rsp_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [IDXW-1:0]   n_q, n_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              a_ovf_q, a_ovf_d;
    logic              b_ovf_q, b_ovf_d;
    logic [WIDTH-1:0]  f_q, f_d;
    logic              ovf_q, ovf_d;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic [IDXW-1:0]   grant_n;
    logic              found;
    int unsigned       idx;
    logic [WIDTH:0]    sum;

    // Search starts just after the last served requester, so it has lowest priority.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        grant_n  = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
                grant_n     = req_index[idx*IDXW +: IDXW];
            end
        end
    end

    assign req_ready = (clr && state_q == StIdle) ? grant : '0;
    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = id_q;
    assign rsp_f     = f_q;
    assign rsp_ovf   = ovf_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        f_d     = f_q;
        ovf_d   = ovf_q;
        sum     = {1'b0, a_q} + {1'b0, b_q};
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    id_d    = grant_id;
                    n_d     = grant_n;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = WIDTH'(1);
                    a_ovf_d = 1'b0;
                    b_ovf_d = 1'b0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == n_q) begin
                    f_d     = a_q;
                    ovf_d   = a_ovf_q;
                    state_d = StResp;
                end else begin
                    // Sticky flags keep the overflow indication exact after wrap-around.
                    a_d     = b_q;
                    a_ovf_d = b_ovf_q;
                    b_d     = sum[WIDTH-1:0];
                    b_ovf_d = b_ovf_q | a_ovf_q | sum[WIDTH];
                    cnt_d   = cnt_q + IDXW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    ptr_d   = id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= StIdle;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            f_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
            f_q     <= f_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Directed and randomized bench for fib_job_scheduler against a round-robin / Fibonacci model.
module tb_fib_job_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 14;
    localparam int IDXW  = 5;

    logic              clk = 1'b0;
    logic              clr;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*IDXW-1:0] req_index;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [WIDTH-1:0]  rsp_f;
    logic              rsp_ovf;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int ptr_m;

    always #5 clk = ~clk;

    fib_job_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_index (req_index),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint fib(input int n);
        longint a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete job: grant, latency, result, optional back-pressure, handshake.
    task automatic serve(input logic [NREQ-1:0] v, input logic [NREQ*IDXW-1:0] idx,
                         input bit scramble, input bit hold, input string tag);
        int     w, n, cyc;
        longint fv;
        w  = rr_pick(v);
        n  = int'(idx[w*IDXW +: IDXW]);
        fv = fib(n);
        rsp_ready = !hold;
        req_valid = v;
        req_index = idx;
        #1;
        check({tag, ":grant"}, 32'(req_ready), 32'(1 << w));
        tick();
        if (scramble) req_index = (NREQ*IDXW)'($urandom);
        check({tag, ":busy_calc"}, 32'(busy), 1);
        check({tag, ":rdy_calc"}, 32'(req_ready), 0);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, ":latency"}, cyc, n + 1);
        check({tag, ":id"}, 32'(rsp_id), w);
        check({tag, ":f"}, 32'(rsp_f), 32'(fv % (64'd1 << WIDTH)));
        check({tag, ":ovf"}, 32'(rsp_ovf), 32'(fv > ((64'd1 << WIDTH) - 1)));
        if (hold) begin
            repeat (5) begin
                tick();
                check({tag, ":hold_valid"}, 32'(rsp_valid), 1);
                check({tag, ":hold_f"}, 32'(rsp_f), 32'(fv % (64'd1 << WIDTH)));
                check({tag, ":hold_id"}, 32'(rsp_id), w);
                check({tag, ":hold_rdy"}, 32'(req_ready), 0);
                check({tag, ":hold_busy"}, 32'(busy), 1);
            end
            rsp_ready = 1'b1;
        end
        tick();
        check({tag, ":drop_valid"}, 32'(rsp_valid), 0);
        check({tag, ":idle"}, 32'(busy), 0);
        ptr_m = w;
    endtask

    initial begin
        logic [NREQ*IDXW-1:0] all3;
        int seq1[$] = '{0, 1, 2, 10, 20, 21, 22, 31};
        all3 = {5'd3, 5'd3, 5'd3, 5'd3};

        clr       = 1'b0;
        req_valid = '1;
        req_index = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst:req_ready", 32'(req_ready), 0);
        check("rst:rsp_valid", 32'(rsp_valid), 0);
        check("rst:busy", 32'(busy), 0);
        check("rst:rsp_f", 32'(rsp_f), 0);
        check("rst:rsp_id", 32'(rsp_id), 0);
        check("rst:rsp_ovf", 32'(rsp_ovf), 0);
        clr   = 1'b1;
        ptr_m = NREQ - 1;

        // All requesters contending from a fresh reset: order 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            check("rr:expected_order", rr_pick(4'b1111), i % NREQ);
            serve(4'b1111, all3, 1'b0, 1'b0, "rr");
        end

        foreach (seq1[i]) serve(4'b0001, (NREQ*IDXW)'(seq1[i]), 1'b0, 1'b0, "req0");

        serve(4'b0001, (NREQ*IDXW)'(5), 1'b0, 1'b1, "backpressure");

        // Reset in the middle of a long job.
        req_valid = 4'b0001;
        req_index = (NREQ*IDXW)'(15);
        #1;
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("midrst:busy_before", 32'(busy), 1);
        clr       = 1'b0;
        req_valid = 4'b1001;
        #1;
        check("midrst:rdy_in_clr", 32'(req_ready), 0);
        tick();
        check("midrst:busy", 32'(busy), 0);
        check("midrst:rsp_valid", 32'(rsp_valid), 0);
        req_valid = '0;
        clr       = 1'b1;
        ptr_m     = NREQ - 1;
        repeat (20) tick();
        check("midrst:no_rsp", 32'(rsp_valid), 0);
        serve(4'b1001, {5'd4, 5'd0, 5'd0, 5'd7}, 1'b0, 1'b0, "post_rst");

        serve(4'b1000, (NREQ*IDXW)'($urandom), 1'b1, 1'b0, "req3");
        serve(4'b0100, (NREQ*IDXW)'($urandom), 1'b1, 1'b0, "wrap_req2");

        for (int i = 0; i < 25; i++) begin
            serve(4'($urandom_range(1, 15)), (NREQ*IDXW)'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
